// File: rtl/pru_pkg.sv
// Shared types for the PRU draw-command scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pru_pkg;

  localparam int CMD_W = 42;

  typedef enum logic [1:0] {
    RECT   = 2'b00,
    CIRCLE = 2'b01
  } shape_e;

  // Shape is kept as raw bits so unknown encodings are forwarded untouched;
  // the PRU decides what to do with them.
  typedef struct packed {
    logic [1:0] shape;
    logic [1:0] color;
    logic [9:0] row;
    logic [8:0] col;
    logic [9:0] width;
    logic [8:0] hr;
  } pru_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pru_cmd_fifo.sv
// Synchronous command FIFO with show-ahead head (dout valid whenever !empty).
// Latency: a push at edge N is visible on dout/count after edge N.
// Backpressure: caller must not push when full unless it pops in the same cycle.
// Ports: clk, rst_n | push, din | pop, dout | full, empty, count.
module pru_cmd_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it until count says it is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pru_draw_scheduler.sv
// Round-robin arbitrates two draw requesters into a queue and issues one command at a time to the PRU.
// Latency: accept at edge N into an idle, empty scheduler -> pru_start high from edge N+2.
// Backpressure: req_ready drops while the queue is full and no pop is happening this cycle.
// Ports: req_valid/req_ready/req_cmd (port0 = CPU MMIO, port1 = sprite logic), pru_* (engine command
//        + start/busy/done handshake), q_count/sched_idle (status), timeout_err/err_clr (watchdog).
module pru_draw_scheduler
  import pru_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 400000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*CMD_W-1:0]      req_cmd,
  output logic                    pru_start,
  output logic [1:0]              pru_shape,
  output logic [1:0]              pru_color,
  output logic [9:0]              pru_row,
  output logic [8:0]              pru_col,
  output logic [9:0]              pru_width,
  output logic [8:0]              pru_hr,
  input  logic                    pru_busy,
  input  logic                    pru_done,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic                    sched_idle,
  output logic                    timeout_err,
  input  logic                    err_clr
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_e       state, state_nxt;
  logic               rr_ptr;
  logic [1:0]         grant;
  logic               push, pop, full, empty, can_push;
  logic [CMD_W-1:0]   push_cmd, head_dout;
  pru_cmd_t           cmd_q;
  logic [WD_W-1:0]    wd_cnt;
  logic               wd_hit;
  logic               start_nxt;
  logic               err_set;

  // ---------------- arbiter ----------------
  // A pop frees a slot in the same cycle, so a full queue can still take a push.
  assign can_push = !full || pop;

  always_comb begin
    grant = 2'b00;
    if (can_push) begin
      if (rr_ptr == 1'b0) begin
        if      (req_valid[0]) grant = 2'b01;
        else if (req_valid[1]) grant = 2'b10;
      end else begin
        if      (req_valid[1]) grant = 2'b10;
        else if (req_valid[0]) grant = 2'b01;
      end
    end
  end

  assign req_ready = grant;
  assign push      = |grant;
  assign push_cmd  = grant[1] ? req_cmd[CMD_W +: CMD_W] : req_cmd[0 +: CMD_W];

  // After serving port 0 favour port 1, and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= 1'b0;
    else if (push) rr_ptr <= grant[0];
  end

  pru_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_cmd),
    .dout  (head_dout),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // ---------------- issue FSM ----------------
  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty)                state_nxt = ISSUE;
      ISSUE:   if (pru_done || wd_hit)    state_nxt = RELEASE;
      RELEASE: if (!pru_done && !pru_busy) state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // start_nxt is registered, so start lags ISSUE entry by one cycle and
  // drops on the same edge that leaves ISSUE.
  always_comb begin
    pop       = 1'b0;
    start_nxt = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE:  pop = !empty;
      ISSUE: begin
        start_nxt = !(pru_done || wd_hit);
        err_set   = !pru_done && wd_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pru_start   <= 1'b0;
      cmd_q       <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      pru_start <= start_nxt;
      // Pop is the only way into ISSUE, so it doubles as the watchdog clear.
      if (pop) begin
        cmd_q  <= head_dout;
        wd_cnt <= '0;
      end else if (state == ISSUE && !(&wd_cnt)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (err_clr)      timeout_err <= 1'b0;
      else if (err_set) timeout_err <= 1'b1;
    end
  end

  assign pru_shape  = cmd_q.shape;
  assign pru_color  = cmd_q.color;
  assign pru_row    = cmd_q.row;
  assign pru_col    = cmd_q.col;
  assign pru_width  = cmd_q.width;
  assign pru_hr     = cmd_q.hr;
  assign sched_idle = empty && (state == IDLE);

endmodule
